// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared types and parameter checks for the sequential logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

  typedef enum logic [1:0] {
    LU_AND  = 2'b00,
    LU_OR   = 2'b01,
    LU_XOR  = 2'b10,
    LU_ANDN = 2'b11
  } lu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lu_state_e;

  function automatic bit lu_width_ok(input int width, input int slice);
    return (slice >= 1) && ((width % slice) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_if
// Description : Operand and result handshakes of the sequential logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zf;
  logic             out_sf;
  logic             out_of;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zf, out_sf, out_of, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zf, out_sf, out_of, busy
  );

endinterface
`default_nettype wire

// File: rtl/lu_slice.sv
`default_nettype none
// ============================================================================
// Module      : lu_slice
// Description : Combinational SLICE-bit AND/OR/XOR/ANDN built from per-bit gates.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  lu_op_e           op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign y[i] = (op == LU_AND) ? (a[i] &  b[i]) :
                  (op == LU_OR)  ? (a[i] |  b[i]) :
                  (op == LU_XOR) ? (a[i] ^  b[i]) :
                                   (a[i] & ~b[i]);
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_seq
// Description : Multi-cycle bitwise logic unit, one SLICE per cycle, Y86 flags.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  logic_unit_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (!lu_width_ok(WIDTH, SLICE)) begin : g_bad_width
    $error("logic_unit_seq: WIDTH must be a positive multiple of SLICE");
  end

  lu_state_e        r_state;
  lu_state_e        w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  lu_op_e           r_op;
  logic [WIDTH-1:0] r_result;
  logic [IDXW-1:0]  r_idx;
  logic             r_zacc;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;

  int               w_base;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_slice;
  logic             w_slice_zero;
  logic             w_last;

  assign w_base       = int'(r_idx) * SLICE;
  assign w_a_slice    = r_a[w_base +: SLICE];
  assign w_b_slice    = r_b[w_base +: SLICE];
  assign w_slice_zero = (w_slice == '0);
  assign w_last       = (r_idx == IDXW'(NSLICE - 1));

  lu_slice #(.SLICE(SLICE)) u_slice (
    .op (r_op),
    .a  (w_a_slice),
    .b  (w_b_slice),
    .y  (w_slice)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)        w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE);
    bus.out_valid = (r_state == ST_DONE);
    bus.busy      = (r_state != ST_IDLE);
  end

  // Flags are registered together with the final slice so they stay aligned
  // with out_result for the whole DONE interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= LU_AND;
      r_result <= '0;
      r_idx    <= '0;
      r_zacc   <= 1'b0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
    end else begin
      r_of <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_op     <= lu_op_e'(bus.in_op);
            r_result <= '0;
            r_idx    <= '0;
            r_zacc   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_result[w_base +: SLICE] <= w_slice;
          r_zacc                    <= r_zacc & w_slice_zero;
          if (w_last) begin
            r_zf <= r_zacc & w_slice_zero;
            r_sf <= w_slice[SLICE-1];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result = r_result;
  assign bus.out_zf     = r_zf;
  assign bus.out_sf     = r_sf;
  assign bus.out_of     = r_of;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_seq
// Description : Self-checking bench for logic_unit_seq at 64/16, 64/64 and 32/8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [1:0]  drv_op = 2'b00;
  logic [63:0] drv_a = '0;
  logic [63:0] drv_b = '0;

  logic_unit_if #(.WIDTH(64)) lu0 ();
  logic_unit_if #(.WIDTH(64)) lu1 ();
  logic_unit_if #(.WIDTH(32)) lu2 ();

  assign lu0.in_valid  = drv_valid && (sel == 0);
  assign lu1.in_valid  = drv_valid && (sel == 1);
  assign lu2.in_valid  = drv_valid && (sel == 2);
  assign lu0.out_ready = drv_ready && (sel == 0);
  assign lu1.out_ready = drv_ready && (sel == 1);
  assign lu2.out_ready = drv_ready && (sel == 2);
  assign lu0.in_op = drv_op;
  assign lu1.in_op = drv_op;
  assign lu2.in_op = drv_op;
  assign lu0.in_a  = drv_a;
  assign lu1.in_a  = drv_a;
  assign lu2.in_a  = drv_a[31:0];
  assign lu0.in_b  = drv_b;
  assign lu1.in_b  = drv_b;
  assign lu2.in_b  = drv_b[31:0];

  logic_unit_seq #(.WIDTH(64), .SLICE(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(lu0.slave));
  logic_unit_seq #(.WIDTH(64), .SLICE(64)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(lu1.slave));
  logic_unit_seq #(.WIDTH(32), .SLICE(8))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(lu2.slave));

  logic        obs_valid, obs_in_ready, obs_busy, obs_zf, obs_sf, obs_of;
  logic [63:0] obs_result;
  always_comb begin
    obs_valid = lu0.out_valid; obs_in_ready = lu0.in_ready; obs_busy = lu0.busy;
    obs_zf = lu0.out_zf; obs_sf = lu0.out_sf; obs_of = lu0.out_of;
    obs_result = lu0.out_result;
    if (sel == 1) begin
      obs_valid = lu1.out_valid; obs_in_ready = lu1.in_ready; obs_busy = lu1.busy;
      obs_zf = lu1.out_zf; obs_sf = lu1.out_sf; obs_of = lu1.out_of;
      obs_result = lu1.out_result;
    end else if (sel == 2) begin
      obs_valid = lu2.out_valid; obs_in_ready = lu2.in_ready; obs_busy = lu2.busy;
      obs_zf = lu2.out_zf; obs_sf = lu2.out_sf; obs_of = lu2.out_of;
      obs_result = {32'h0, lu2.out_result};
    end
  end

  typedef struct {
    logic [63:0] res;
    logic        zf;
    logic        sf;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic int width_of(int s);
    return (s == 2) ? 32 : 64;
  endfunction

  function automatic int lat_of(int s);
    return (s == 1) ? 1 : 4;
  endfunction

  function automatic exp_t model(logic [1:0] op, logic [63:0] a, logic [63:0] b, int w);
    exp_t        e;
    logic [63:0] r;
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & ~b;
    endcase
    r     = r & m;
    e.res = r;
    e.zf  = (r == 64'h0);
    e.sf  = r[w-1];
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    drv_op = op; drv_a = a; drv_b = b; drv_valid = 1'b1;
    check("in_ready_before_accept", obs_in_ready, 1);
    exp_q.push_back(model(op, a, b, width_of(sel)));
    tick();
    drv_valid = 1'b0;
    check("busy_after_accept", obs_busy, 1);
  endtask

  // Waits for out_valid, scores the oldest expectation, optionally holds
  // out_ready low (pulsing in_valid with junk), then completes the handshake.
  task automatic collect(string tag, int exp_lat, int hold, bit pulse);
    int   n;
    exp_t e;
    n = 0;
    while (!obs_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    if (!obs_valid) return;
    check({tag, "_result"}, obs_result, e.res);
    check({tag, "_zf"}, obs_zf, e.zf);
    check({tag, "_sf"}, obs_sf, e.sf);
    check({tag, "_of"}, obs_of, 0);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        drv_valid = 1'b1; drv_a = {$urandom, $urandom}; drv_b = {$urandom, $urandom};
        drv_op = 2'($urandom_range(0, 3));
      end
      tick();
      check({tag, "_hold_result"}, obs_result, e.res);
      check({tag, "_hold_zf"}, obs_zf, e.zf);
      check({tag, "_hold_valid"}, obs_valid, 1);
      check({tag, "_hold_in_ready"}, obs_in_ready, 0);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    check({tag, "_valid_dropped"}, obs_valid, 0);
    check({tag, "_in_ready_back"}, obs_in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=timeout required=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [63:0] a, b;
    int          k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", obs_valid, 0);
    check("rst_out_result", obs_result, 0);
    check("rst_out_zf", obs_zf, 0);
    check("rst_out_sf", obs_sf, 0);
    check("rst_out_of", obs_of, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_in_ready", obs_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(LU_AND, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    collect("and_default", 4, 0, 1'b0);
    check("and_const", model(2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64).res,
          64'h0F0F_0000_0F0F_0000);

    issue(LU_XOR, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    collect("xor_self", 4, 0, 1'b0);
    issue(LU_ANDN, 64'h8000_0000_0000_0000, 64'h0);
    collect("andn_msb", 4, 0, 1'b0);

    issue(LU_OR, 64'h1234_5678_0000_0000, 64'h0000_0000_9ABC_DEF0);
    collect("backpressure", 4, 10, 1'b1);
    tick();
    check("bp_nothing_queued", obs_busy, 0);
    issue(LU_XOR, 64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_FFFF_0000_0000);
    collect("after_bp", 4, 0, 1'b0);

    issue(LU_ANDN, 64'hDEAD_BEEF_CAFE_F00D, 64'h00FF_00FF_00FF_00FF);
    for (int i = 0; i < 3; i++) begin
      drv_a = {$urandom, $urandom}; drv_b = {$urandom, $urandom}; drv_op = 2'($urandom_range(0, 3));
      tick();
    end
    collect("operand_change", 1, 0, 1'b0);

    issue(LU_OR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", obs_valid, 0);
    check("abort_busy", obs_busy, 0);
    check("abort_out_result", obs_result, 0);
    check("abort_in_ready", obs_in_ready, 1);
    check("abort_zf", obs_zf, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_in_ready_release", obs_in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", obs_valid, 0);
    end
    issue(LU_OR, 64'h0, 64'h1);
    collect("or_after_abort", 4, 0, 1'b0);

    for (int s = 1; s <= 2; s++) begin
      sel = s;
      tick();
      for (int i = 0; i < 1000; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        k  = $urandom_range(0, 7);
        if (k == 0) begin op = 2'b10; b = a; end
        else if (k == 1) a = 64'h0;
        else if (k == 2) begin op = 2'b01; a[63] = 1'b1; a[31] = 1'b1; end
        issue(op, a, b);
        collect((s == 1) ? "sweep_64_64" : "sweep_32_8", lat_of(s), 0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
